param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/sync_fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 22 ++
 rtl/param_sync_fifo.sv | 100 ++++++++++
 tb/tb_param_sync_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and the occupancy-count width helper for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_AE_LVL = 2;

  // Occupancy must represent 0..2**addr_w inclusive, hence one extra bit.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO; pop data registered one cycle after rd_ok, or shown head-first with FIFO_FWFT_EN.
// Latency: push visible to pop on the next cycle; flags decode the registered count.
// Backpressure: pushes while full (no pop) and pops while empty are dropped and raise sticky overflow/underflow.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AF_LVL = (2**ADDR_W) - 2,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            buf_in,
  input  logic                         rd_en,
  input  logic                         err_clr,
  output logic [DATA_W-1:0]            buf_out,
  output logic                         buf_empty,
  output logic                         buf_full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [cnt_w(ADDR_W)-1:0]     fifo_counter,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_w(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ok;
  logic              rd_ok;

  assign buf_empty    = (fifo_counter == '0);
  assign buf_full     = (fifo_counter == CNT_W'(DEPTH));
  assign almost_empty = (fifo_counter <= CNT_W'(AE_LVL));
  assign almost_full  = (fifo_counter >= CNT_W'(AF_LVL));

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign rd_ok = rd_en && !buf_empty;
  assign wr_ok = wr_en && (!buf_full || rd_ok);

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (buf_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + 1'b1;
        2'b01:   fifo_counter <= fifo_counter - 1'b1;
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

  // Error set takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && buf_full && !rd_ok) overflow <= 1'b1;
      else if (err_clr)                overflow <= 1'b0;
      if (rd_en && buf_empty)          underflow <= 1'b1;
      else if (err_clr)                underflow <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  assign buf_out = buf_empty ? '0 : rd_data;
`else
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       out_q <= '0;
    else if (rd_ok) out_q <= rd_data;
  end

  assign buf_out = out_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (DATA_W=8, ADDR_W=3); adapts pop timing when FIFO_FWFT_EN is defined.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] buf_in;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] buf_out;
  logic       buf_empty;
  logic       buf_full;
  logic       almost_empty;
  logic       almost_full;
  logic [3:0] fifo_counter;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  param_sync_fifo #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .buf_in       (buf_in),
    .rd_en        (rd_en),
    .err_clr      (err_clr),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_counter (fifo_counter),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic op(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en   = w;
    buf_in  = d;
    rd_en   = r;
    err_clr = c;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic w, input logic [7:0] d, input logic [7:0] exp);
`ifdef FIFO_FWFT_EN
    chk(tag, 32'(buf_out), 32'(exp));
    op(w, d, 1'b1, 1'b0);
`else
    op(w, d, 1'b1, 1'b0);
    chk(tag, 32'(buf_out), 32'(exp));
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cnt"},   32'(fifo_counter), 32'd0);
    chk({tag, "_empty"}, 32'(buf_empty),    32'd1);
    chk({tag, "_full"},  32'(buf_full),     32'd0);
    chk({tag, "_ae"},    32'(almost_empty), 32'd1);
    chk({tag, "_af"},    32'(almost_full),  32'd0);
    chk({tag, "_out"},   32'(buf_out),      32'd0);
    chk({tag, "_ovf"},   32'(overflow),     32'd0);
    chk({tag, "_udf"},   32'(underflow),    32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    buf_in  = 8'h00;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    #2 rst = 1'b0;
    #1 chk_reset_state("por");
    @(posedge clk);
    #1 rst = 1'b1;

    // Fill 0x11..0x88, watching both threshold edges.
    for (int i = 0; i < 8; i++) begin
      op(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      chk("fill_cnt", 32'(fifo_counter), 32'(i + 1));
      chk("fill_af",  32'(almost_full),  32'((i + 1) >= 6));
      chk("fill_ae",  32'(almost_empty), 32'((i + 1) <= 2));
    end
    chk("fill_full",  32'(buf_full),  32'd1);
    chk("fill_empty", 32'(buf_empty), 32'd0);

    // Push while full is dropped and flags overflow until cleared.
    op(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ovf_set",  32'(overflow),     32'd1);
    chk("ovf_cnt",  32'(fifo_counter), 32'd8);
    chk("ovf_full", 32'(buf_full),     32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr",  32'(overflow),     32'd0);

    // Push and pop together while full.
    pop_chk("full_rw_data", 1'b1, 8'hAA, 8'h11);
    chk("full_rw_cnt",  32'(fifo_counter), 32'd8);
    chk("full_rw_full", 32'(buf_full),     32'd1);
    chk("full_rw_ovf",  32'(overflow),     32'd0);

    for (int i = 1; i < 8; i++)
      pop_chk("drain_data", 1'b0, 8'h00, 8'(8'h11 * (i + 1)));
    pop_chk("drain_last", 1'b0, 8'h00, 8'hAA);
    chk("drain_empty", 32'(buf_empty),    32'd1);
    chk("drain_cnt",   32'(fifo_counter), 32'd0);

    // Pop while empty.
    op(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow),    32'd1);
    chk("udf_cnt", 32'(fifo_counter), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("udf_out_hold", 32'(buf_out), 32'hAA);
`endif
    op(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_set_wins", 32'(underflow), 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow), 32'd0);

    // Push and pop together while empty: only the push lands.
    op(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("empty_rw_cnt",   32'(fifo_counter), 32'd1);
    chk("empty_rw_empty", 32'(buf_empty),    32'd0);
    chk("empty_rw_udf",   32'(underflow),    32'd1);
    pop_chk("empty_rw_data", 1'b0, 8'h00, 8'h5A);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("empty_rw_clr", 32'(underflow), 32'd0);

    // Twelve words streamed through with a lag of three, crossing the pointer wrap.
    for (int i = 0; i < 3; i++) op(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    chk("wrap_prefill", 32'(fifo_counter), 32'd3);
    for (int i = 3; i < 12; i++) begin
      pop_chk("wrap_data", 1'b1, 8'(8'hC0 + i), 8'(8'hC0 + i - 3));
      chk("wrap_cnt", 32'(fifo_counter), 32'd3);
    end
    for (int i = 9; i < 12; i++) pop_chk("wrap_tail", 1'b0, 8'h00, 8'(8'hC0 + i));
    chk("wrap_empty", 32'(buf_empty), 32'd1);

    // Asynchronous reset in the middle of a cycle with five words stored.
    for (int i = 0; i < 5; i++) op(1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    chk("mid_cnt", 32'(fifo_counter), 32'd5);
    #2 rst = 1'b0;
    #1 chk_reset_state("mid_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    op(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_cnt", 32'(fifo_counter), 32'd1);
    pop_chk("post_rst_data", 1'b0, 8'h00, 8'h3C);
    chk("post_rst_empty", 32'(buf_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
